sim_frame_sequencer: RTL and testbench
======================================

Name: sim_frame_sequencer

Overview:
- Frame-level controller for the SPH simulator pipeline.
- Decides when a simulation frame starts: free-running on a programmable frame period, or single-stepped from a button.
- Per frame: starts the scheduler, waits for the scheduler and all per-particle updates to finish, then streams the particle buffer out over the renderer read port.
- Adds frame counting, overrun detection and a compute watchdog, none of which exist in the current top level.

Parameters:
- PARTICLE_COUNT, 4: particles per frame; equals the number of update_finished_in pulses expected per frame.
- DIMS, 1: spatial dimensions.
- ELEMENTS, PARTICLE_COUNT*DIMS*2: buffer words streamed per frame.
- ADDR_WIDTH, $clog2(ELEMENTS): stream address width.
- READ_LATENCY, 2: cycles from stream_addr_out to valid data on the buffer stream port.
- FRAME_PERIOD, 10_000_000: clock cycles between free-run ticks (10 Hz at 100 MHz).
- TIMEOUT_CYCLES, 1_000_000: maximum cycles allowed in the COMPUTE state.
- FRAME_CNT_WIDTH, 16: width of frame_count_out.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- run_mode_in  in  1  1 = free-run on tick, 0 = single-step
- step_in  in  1  step request, level; rising edge detected internally
- clear_flags_in  in  1  clears the sticky flags
- sched_done_in  in  1  scheduler frame_done pulse
- update_finished_in  in  1  updater per-particle completion pulse
- sched_start_out  out  1  one-cycle new_frame pulse to the scheduler
- stream_enable_out  out  1  buffer port-C stream enable
- stream_addr_out  out  ADDR_WIDTH  buffer port-C address
- stream_valid_out  out  1  port-C data valid, aligned with doutc
- frame_done_out  out  1  one-cycle pulse when a frame completes successfully
- busy_out  out  1  high whenever the state is not IDLE
- frame_count_out  out  FRAME_CNT_WIDTH  completed frames; wraps on overflow
- overrun_out  out  1  sticky: a tick arrived while busy
- timeout_out  out  1  sticky: watchdog fired
- last_frame_cycles_out  out  32  see Optional Feature

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE, all counters 0, valid pipeline cleared, step edge register 0.
  - Reset in any state returns to IDLE on the next edge; no pulse is emitted.
- Tick generator:
  - Free-running counter from 0 to FRAME_PERIOD-1; tick is high on the cycle the count equals FRAME_PERIOD-1, then the counter wraps to 0.
  - Runs independently of state and of run_mode_in.
- Triggers:
  - step_edge = step_in & ~step_q.
  - trigger = run_mode_in ? tick : step_edge.
- IDLE:
  - Trigger at cycle t moves to START; sched_start_out is high during cycle t+1 only.
- START:
  - Always moves to COMPUTE.
  - Clears the update counter and the watchdog counter, and clears the seen_done flag.
- COMPUTE:
  - sched_done_in sets seen_done.
  - Each update_finished_in increments upd_cnt, saturating at PARTICLE_COUNT.
  - Pulses may arrive in either order or in the same cycle.
  - Exit to STREAM on the first cycle where seen_done is set and upd_cnt equals PARTICLE_COUNT, counting same-cycle pulses.
  - Watchdog: if TIMEOUT_CYCLES elapse without exit, set timeout_out and return to IDLE. The frame is aborted: no frame_done_out pulse, frame_count_out not incremented.
- STREAM:
  - stream_enable_out is high for exactly ELEMENTS cycles while stream_addr_out steps 0, 1, …, ELEMENTS-1.
  - After the last address, enable drops and the address holds for READ_LATENCY drain cycles, then the state moves to DONE.
- stream_valid_out is stream_enable_out delayed by READ_LATENCY cycles through a shift register.
- DONE (one cycle):
  - frame_done_out pulses and frame_count_out increments; the state returns to IDLE.
  - A trigger during DONE is treated as busy.
- Busy conditions:
  - A tick in any non-IDLE state while run_mode_in=1 sets overrun_out; the tick is dropped, not queued.
  - step_edge while busy is ignored and sets no flag.
- Flags: clear_flags_in clears overrun_out and timeout_out. If clear and set occur in the same cycle, set wins.
- A sched_done_in or update_finished_in pulse outside COMPUTE is ignored.

Optional Feature:
- Macro SIM_SEQ_STATS_EN.
- Defined:
  - A 32-bit cycle counter runs from START to DONE and saturates at all-ones.
  - On DONE it is loaded into last_frame_cycles_out, which holds its value until the next DONE.
  - Aborted frames leave last_frame_cycles_out unchanged.
- Undefined: last_frame_cycles_out is tied to 0 and the counter is not built.

Decomposition:
- Package sim_seq_pkg holds:
  - typedef enum logic [2:0] {IDLE, START, COMPUTE, STREAM, DONE} seq_state_t;
  - the default READ_LATENCY constant.
- Sub-module frame_tick_gen: parametrised period counter producing the tick; instantiated once.

Test Plan (PARTICLE_COUNT=4, DIMS=1, ELEMENTS=8, FRAME_PERIOD=100, TIMEOUT_CYCLES=50, READ_LATENCY=2):
- Single-step: run_mode_in=0, step_in rises at cycle 10 → sched_start_out at 11; drive sched_done_in at 20 and 4 update pulses at 21–24 → addresses 0..7 on cycles 26–33; stream_valid_out on 28–35; frame_done_out once; frame_count_out = 1.
- Same-cycle completion: 4th update pulse coincides with sched_done_in → STREAM entered the next cycle; updates sent before sched_done_in are also counted correctly.
- Watchdog: drive only 3 update pulses → timeout_out=1 exactly 50 cycles after entering COMPUTE; returns to IDLE; frame_count_out unchanged; clear_flags_in clears the flag.
- Free-run overrun: run_mode_in=1, hold sched_done_in low beyond 100 cycles with TIMEOUT_CYCLES raised to 500 → overrun_out=1; no second sched_start_out while busy.
- Reset mid-STREAM: rst_in at address 3 → next cycle stream_enable_out=0, stream_valid_out=0, busy_out=0, no frame_done_out.
- SIM_SEQ_STATS_EN defined, single-step frame as in the first scenario → last_frame_cycles_out = DONE cycle − START cycle.

Source files
------------

// File: rtl/sim_seq_pkg.sv
// Shared types and defaults for the SPH frame sequencer.
//   seq_state_t      : frame-level FSM state encoding
//   DEF_READ_LATENCY : default buffer stream-port read latency in cycles
package sim_seq_pkg;
    typedef enum logic [2:0] {IDLE, START, COMPUTE, STREAM, DONE} seq_state_t;
    localparam int DEF_READ_LATENCY = 2;
endpackage

// File: rtl/sim_frame_sequencer_tick.sv
// frame_tick_gen: free-running period counter for free-run frame timing.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   tick_o : high for one cycle when the count reaches PERIOD-1
module frame_tick_gen #(
    parameter int PERIOD = 10_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);
    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LAST);
    assign cnt_d  = tick_o ? '0 : cnt_q + CW'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/sim_frame_sequencer.sv
// sim_frame_sequencer: frame-level controller for the SPH simulator.
// Starts a frame on a free-run tick or a step button edge, kicks the
// scheduler, waits for scheduler done plus PARTICLE_COUNT update pulses,
// then streams the particle buffer out over the renderer read port.
// Ports:
//   clk_in, rst_in (sync, active high)
//   run_mode_in, step_in, clear_flags_in     : control
//   sched_done_in, update_finished_in        : completion pulses
//   sched_start_out                          : new-frame pulse to scheduler
//   stream_enable_out/addr_out/valid_out     : buffer port-C stream
//   frame_done_out, busy_out, frame_count_out: frame status
//   overrun_out, timeout_out                 : sticky error flags
//   last_frame_cycles_out                    : START->DONE cycle count
// Build option: SIM_SEQ_STATS_EN enables the frame cycle statistics;
// otherwise last_frame_cycles_out is tied to 0.
module sim_frame_sequencer
    import sim_seq_pkg::*;
#(
    parameter int PARTICLE_COUNT  = 4,
    parameter int DIMS            = 1,
    parameter int ELEMENTS        = PARTICLE_COUNT * DIMS * 2,
    parameter int ADDR_WIDTH      = $clog2(ELEMENTS),
    parameter int READ_LATENCY    = DEF_READ_LATENCY,
    parameter int FRAME_PERIOD    = 10_000_000,
    parameter int TIMEOUT_CYCLES  = 1_000_000,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       run_mode_in,
    input  logic                       step_in,
    input  logic                       clear_flags_in,
    input  logic                       sched_done_in,
    input  logic                       update_finished_in,
    output logic                       sched_start_out,
    output logic                       stream_enable_out,
    output logic [ADDR_WIDTH-1:0]      stream_addr_out,
    output logic                       stream_valid_out,
    output logic                       frame_done_out,
    output logic                       busy_out,
    output logic [FRAME_CNT_WIDTH-1:0] frame_count_out,
    output logic                       overrun_out,
    output logic                       timeout_out,
    output logic [31:0]                last_frame_cycles_out
);
    localparam int UPD_W = $clog2(PARTICLE_COUNT + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SC_W  = $clog2(ELEMENTS + READ_LATENCY + 2);
    localparam logic [UPD_W-1:0] UPD_FULL = UPD_W'(PARTICLE_COUNT);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SC_W-1:0]  SC_ELEM  = SC_W'(ELEMENTS);
    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(ELEMENTS + READ_LATENCY);

    seq_state_t                 state_q, state_d;
    logic                       step_q;
    logic [UPD_W-1:0]           upd_cnt_q, upd_cnt_d, upd_next;
    logic                       seen_done_q, seen_done_d;
    logic [WD_W-1:0]            wd_q, wd_d;
    logic [SC_W-1:0]            scnt_q, scnt_d;
    logic                       en_q, en_d;
    logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [READ_LATENCY-1:0]    vld_pipe_q;
    logic [FRAME_CNT_WIDTH-1:0] fcnt_q, fcnt_d;
    logic                       ovr_q, ovr_d, tmo_q, tmo_d, tmo_set;
    logic                       tick, step_edge, trigger, done_now;

    frame_tick_gen #(.PERIOD(FRAME_PERIOD)) u_tick (
        .clk_i  (clk_in),
        .rst_i  (rst_in),
        .tick_o (tick)
    );

    assign step_edge = step_in & ~step_q;
    assign trigger   = run_mode_in ? tick : step_edge;
    // Same-cycle pulses count toward the exit condition.
    assign done_now  = seen_done_q | sched_done_in;
    assign upd_next  = (update_finished_in && upd_cnt_q != UPD_FULL)
                     ? upd_cnt_q + UPD_W'(1) : upd_cnt_q;

    always_comb begin
        state_d     = state_q;
        upd_cnt_d   = upd_cnt_q;
        seen_done_d = seen_done_q;
        wd_d        = wd_q;
        scnt_d      = scnt_q;
        en_d        = 1'b0;
        addr_d      = addr_q;
        fcnt_d      = fcnt_q;
        tmo_set     = 1'b0;
        case (state_q)
            IDLE: if (trigger) state_d = START;
            START: begin
                state_d     = COMPUTE;
                upd_cnt_d   = '0;
                seen_done_d = 1'b0;
                wd_d        = '0;
                scnt_d      = '0;
            end
            COMPUTE: begin
                seen_done_d = done_now;
                upd_cnt_d   = upd_next;
                wd_d        = wd_q + WD_W'(1);
                // Completion beats the watchdog when both land together.
                if (done_now && upd_next == UPD_FULL) begin
                    state_d = STREAM;
                end else if (wd_q == WD_LAST) begin
                    tmo_set = 1'b1;
                    state_d = IDLE;
                end
            end
            STREAM: begin
                // Port signals are registered: count k drives address k
                // on the following cycle, then READ_LATENCY drain cycles.
                scnt_d = scnt_q + SC_W'(1);
                if (scnt_q < SC_ELEM) begin
                    en_d   = 1'b1;
                    addr_d = scnt_q[ADDR_WIDTH-1:0];
                end
                if (scnt_q == SC_LAST) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                fcnt_d  = fcnt_q + FRAME_CNT_WIDTH'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Set wins over clear for the sticky flags.
    assign ovr_d = (tick & run_mode_in & (state_q != IDLE)) | (ovr_q & ~clear_flags_in);
    assign tmo_d = tmo_set | (tmo_q & ~clear_flags_in);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            step_q      <= 1'b0;
            upd_cnt_q   <= '0;
            seen_done_q <= 1'b0;
            wd_q        <= '0;
            scnt_q      <= '0;
            en_q        <= 1'b0;
            addr_q      <= '0;
            vld_pipe_q  <= '0;
            fcnt_q      <= '0;
            ovr_q       <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_in;
            upd_cnt_q   <= upd_cnt_d;
            seen_done_q <= seen_done_d;
            wd_q        <= wd_d;
            scnt_q      <= scnt_d;
            en_q        <= en_d;
            addr_q      <= addr_d;
            vld_pipe_q[0] <= en_q;
            for (int i = 1; i < READ_LATENCY; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
            fcnt_q      <= fcnt_d;
            ovr_q       <= ovr_d;
            tmo_q       <= tmo_d;
        end
    end

`ifdef SIM_SEQ_STATS_EN
    logic [31:0] cyc_q, last_q;
    // cyc_q reads 1 on the cycle after START, so on DONE it equals DONE-START.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cyc_q  <= '0;
            last_q <= '0;
        end else begin
            if (state_q == START)                     cyc_q <= 32'd1;
            else if (state_q != IDLE && cyc_q != '1)  cyc_q <= cyc_q + 32'd1;
            if (state_q == DONE)                      last_q <= cyc_q;
        end
    end
    assign last_frame_cycles_out = last_q;
`else
    assign last_frame_cycles_out = '0;
`endif

    assign sched_start_out   = (state_q == START);
    assign frame_done_out    = (state_q == DONE);
    assign busy_out          = (state_q != IDLE);
    assign stream_enable_out = en_q;
    assign stream_addr_out   = addr_q;
    assign stream_valid_out  = vld_pipe_q[READ_LATENCY-1];
    assign frame_count_out   = fcnt_q;
    assign overrun_out       = ovr_q;
    assign timeout_out       = tmo_q;
endmodule

// File: tb/tb_sim_frame_sequencer.sv
// Directed bench for sim_frame_sequencer: single-step frame, same-cycle
// completion, watchdog, reset mid-stream and free-run overrun.
module tb_sim_frame_sequencer;
    logic clk = 1'b0;
    logic rst, run_mode, step, clr, sdone, upd;
    logic run2, zero2;
    logic st1, en1, vl1, dn1, by1, ov1, to1;
    logic [2:0] ad1;
    logic [15:0] fc1;
    logic [31:0] lc1;
    logic st2, en2, vl2, dn2, by2, ov2, to2;
    logic [2:0] ad2;
    logic [15:0] fc2;
    logic [31:0] lc2;

    int n_chk = 0, n_fail = 0;
    logic [63:0] st_m, en_m, vl_m, dn_m, by_m, to_m;
    logic [2:0]  addr_log [64];

    always #5 clk = ~clk;

    sim_frame_sequencer #(.PARTICLE_COUNT(4), .DIMS(1), .READ_LATENCY(2),
        .FRAME_PERIOD(100), .TIMEOUT_CYCLES(50)) dut (
        .clk_in(clk), .rst_in(rst), .run_mode_in(run_mode), .step_in(step),
        .clear_flags_in(clr), .sched_done_in(sdone), .update_finished_in(upd),
        .sched_start_out(st1), .stream_enable_out(en1), .stream_addr_out(ad1),
        .stream_valid_out(vl1), .frame_done_out(dn1), .busy_out(by1),
        .frame_count_out(fc1), .overrun_out(ov1), .timeout_out(to1),
        .last_frame_cycles_out(lc1));

    sim_frame_sequencer #(.PARTICLE_COUNT(4), .DIMS(1), .READ_LATENCY(2),
        .FRAME_PERIOD(100), .TIMEOUT_CYCLES(500)) dut_ovr (
        .clk_in(clk), .rst_in(rst), .run_mode_in(run2), .step_in(zero2),
        .clear_flags_in(zero2), .sched_done_in(zero2), .update_finished_in(zero2),
        .sched_start_out(st2), .stream_enable_out(en2), .stream_addr_out(ad2),
        .stream_valid_out(vl2), .frame_done_out(dn2), .busy_out(by2),
        .frame_count_out(fc2), .overrun_out(ov2), .timeout_out(to2),
        .last_frame_cycles_out(lc2));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    // Runs n cycles from the current one (cycle 0), logging outputs.
    task automatic run_seq(input int n, input int step_at,
                           input logic [63:0] sd_m, input logic [63:0] up_m);
        st_m = '0; en_m = '0; vl_m = '0; dn_m = '0; by_m = '0; to_m = '0;
        for (int c = 0; c < n; c++) begin
            st_m[c] = st1; en_m[c] = en1; vl_m[c] = vl1;
            dn_m[c] = dn1; by_m[c] = by1; to_m[c] = to1;
            addr_log[c] = ad1;
            step  = (c >= step_at) && (c < step_at + 2);
            sdone = sd_m[c];
            upd   = up_m[c];
            nxt();
        end
        step = 0; sdone = 0; upd = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int st_cyc, ov_cyc, n_st;
        bit found;
        rst = 1; run_mode = 0; step = 0; clr = 0; sdone = 0; upd = 0;
        run2 = 0; zero2 = 0;
        repeat (3) nxt();
        chk("rst_outs", {st1, en1, ad1, vl1, dn1, by1, ov1, to1}, 0);
        chk("rst_cnt", {fc1, lc1}, 0);
        chk("rst_outs2", {st2, en2, ad2, vl2, dn2, by2, ov2, to2, fc2, lc2}, 0);
        rst = 0;
        nxt();

        // Single-step frame.
        run_seq(46, 10, 64'h1 << 20, 64'hF << 21);
        chk("s1_start", st_m, 64'h1 << 11);
        chk("s1_enable", en_m, 64'hFF << 26);
        chk("s1_valid", vl_m, 64'hFF << 28);
        chk("s1_done", dn_m, 64'h1 << 36);
        chk("s1_busy", by_m, (64'h1 << 37) - (64'h1 << 11));
        for (int c = 26; c < 34; c++) chk("s1_addr", addr_log[c], 64'(c - 26));
        chk("s1_addr_hold", {addr_log[34], addr_log[35]}, 6'o77);
        chk("s1_count", fc1, 1);
`ifdef SIM_SEQ_STATS_EN
        chk("s1_cycles", lc1, 25);
`else
        chk("s1_cycles", lc1, 0);
`endif

        // Same-cycle completion, early updates counted.
        run_seq(24, 1, 64'h100, 64'h170);
        chk("s2_start", st_m, 64'h4);
        chk("s2_enable", en_m, 64'hFF << 10);
        chk("s2_valid", vl_m, 64'hFF << 12);
        chk("s2_done", dn_m, 64'h1 << 20);
        chk("s2_addr_first", addr_log[10], 0);
        chk("s2_addr_last", addr_log[17], 7);
        chk("s2_count", fc1, 2);

        // Watchdog: only three updates, no scheduler done.
        run_seq(60, 1, 64'h0, 64'hE0);
        chk("s3_timeout", to_m, (64'h1 << 60) - (64'h1 << 53));
        chk("s3_busy", by_m, (64'h1 << 53) - (64'h1 << 2));
        chk("s3_done", dn_m, 0);
        chk("s3_enable", en_m, 0);
        chk("s3_count", fc1, 2);
        clr = 1; nxt(); clr = 0;
        chk("s3_clear", to1, 0);

        // Reset while address 3 is on the port.
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (en1 && ad1 == 3) begin
                found = 1;
                rst = 1;
            end else begin
                step  = (c >= 1) && (c < 3);
                sdone = (c == 3);
                upd   = (c >= 3) && (c <= 6);
            end
            nxt();
        end
        step = 0; sdone = 0; upd = 0;
        chk("s4_reached_addr3", found, 1);
        chk("s4_after_rst", {en1, vl1, by1, dn1}, 0);
        chk("s4_count", fc1, 0);
        rst = 0;
        dn_m = '0;
        for (int c = 0; c < 15; c++) begin
            dn_m[c] = dn1;
            nxt();
        end
        chk("s4_no_done", dn_m, 0);

        // Free-run overrun on the long-timeout instance.
        run2 = 1; st_cyc = -1; ov_cyc = -1; n_st = 0;
        for (int c = 0; c < 260; c++) begin
            if (st2) begin
                n_st++;
                if (st_cyc < 0) st_cyc = c;
            end
            if (ov2 && ov_cyc < 0) ov_cyc = c;
            nxt();
        end
        chk("s5_start_count", n_st, 1);
        chk("s5_overrun_delay", ov_cyc - st_cyc, 100);
        chk("s5_overrun", ov2, 1);
        chk("s5_busy", by2, 1);
        chk("s5_no_timeout", to2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
